// File: rtl/alu_mc_if.sv
// Execute-stage <-> alu_mc bus: request handshake, operands, completion pulse, result and flags.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, op,
    input  in_ready, out_valid, result, result_hi, zero, negative, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, op,
    output in_ready, out_valid, result, result_hi, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide, with registered result and N/Z/C/V flags.
module alu_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  alu_mc_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADC  = 4'h8;
  localparam logic [3:0] OP_SBC  = 4'h9;
  localparam logic [3:0] OP_SAR  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_out_valid;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;

  logic             w_accept;
  logic             w_multi;
  logic             w_last;

  // Single-cycle datapath signals
  logic [WIDTH-1:0] w_addend;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_add_v;
  logic [SW-1:0]    w_sh;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_sar;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_zn_src;
  logic             w_cmp;
  logic             w_c;
  logic             w_v;
  logic             w_flag_upd;

  // Iterative datapath signals
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dshift;
  logic [WIDTH-1:0] w_ddiff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.zero      = r_z;
  assign bus.negative  = r_n;
  assign bus.carry     = r_c;
  assign bus.overflow  = r_v;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and accept decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_multi     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = bus.in_valid && !rst;
        w_multi  = (bus.op == OP_MUL) || (bus.op == OP_DIVU);
        if (w_accept && w_multi) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_last = (r_cnt == CW'(1));
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Adder operand select: subtraction forms use a + ~b + cin
  always_comb begin
    w_addend = bus.b;
    w_cin    = 1'b0;
    case (bus.op)
      OP_SUB, OP_CMP: begin
        w_addend = ~bus.b;
        w_cin    = 1'b1;
      end
      OP_ADC: w_cin = r_c;
      OP_SBC: begin
        w_addend = ~bus.b;
        w_cin    = r_c;
      end
      default: ;
    endcase
  end

  assign w_sum   = {1'b0, bus.a} + {1'b0, w_addend} + (WIDTH+1)'(w_cin);
  assign w_add_v = (bus.a[WIDTH-1] == w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

  // Extended shifts: the extra bit captures the last bit shifted out (0 when s==0)
  assign w_sh  = bus.b[SW-1:0];
  assign w_shl = {1'b0, bus.a} << w_sh;
  assign w_shr = {bus.a, 1'b0} >> w_sh;
  assign w_sar = (WIDTH+1)'($signed({bus.a, 1'b0}) >>> w_sh);

  // Single-cycle result and flag selection
  always_comb begin
    w_res      = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_cmp      = 1'b0;
    w_flag_upd = 1'b1;
    case (bus.op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      OP_CMP: begin
        w_res = bus.a;
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
        w_cmp = 1'b1;
      end
      OP_AND: w_res = bus.a & bus.b;
      OP_OR:  w_res = bus.a | bus.b;
      OP_XOR: w_res = bus.a ^ bus.b;
      OP_NOT: w_res = ~bus.a;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SAR: begin
        w_res = w_sar[WIDTH:1];
        w_c   = w_sar[0];
      end
      default: w_flag_upd = 1'b0;
    endcase
    w_zn_src = w_cmp ? w_sum[WIDTH-1:0] : w_res;
  end

  // One multiply or divide step; b==0 divide naturally yields all-ones quotient and remainder a
  assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  assign w_dshift = {r_hi, r_lo[WIDTH-1]};
  assign w_ddiff  = w_dshift[WIDTH-1:0] - r_opb;
  assign w_qbit   = (w_dshift >= {1'b0, r_opb});

  always_comb begin
    w_hi_nxt = w_madd[WIDTH:1];
    w_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      w_hi_nxt = w_qbit ? w_ddiff : w_dshift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_qbit};
    end
  end

  // Datapath, iteration counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_out_valid <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && !w_multi) begin
        r_result    <= w_res;
        r_result_hi <= '0;
        r_out_valid <= 1'b1;
        if (w_flag_upd) begin
          r_z <= (w_zn_src == '0);
          r_n <= w_zn_src[WIDTH-1];
          r_c <= w_c;
          r_v <= w_v;
        end
      end else if (w_accept) begin
        r_is_div <= (bus.op == OP_DIVU);
        r_hi     <= '0;
        r_lo     <= bus.a;
        r_opb    <= bus.b;
        r_cnt    <= CW'(WIDTH);
      end else if (r_state == S_BUSY) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_result    <= w_lo_nxt;
          r_result_hi <= w_hi_nxt;
          r_out_valid <= 1'b1;
          if (r_is_div) begin
            r_z <= (w_lo_nxt == '0);
            r_n <= w_lo_nxt[WIDTH-1];
            r_c <= (r_opb == '0);
            r_v <= 1'b0;
          end else begin
            r_z <= ({w_hi_nxt, w_lo_nxt} == '0);
            r_n <= w_hi_nxt[WIDTH-1];
            r_c <= (w_hi_nxt != '0);
            r_v <= (w_hi_nxt != '0);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboarded random + directed bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t q_sb[$];
  exp_t m_st;
  exp_t mon_exp;
  exp_t mon_got;

  alu_mc_if #(.WIDTH(16)) bus ();

  alu_mc #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each op
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input exp_t prev);
    exp_t   e;
    longint ua, ub, sa, sbv, full, sres, p;
    int     s;
    logic   arith;
    logic [15:0] zsrc;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    s = int'(b[3:0]);
    e = prev;
    e.res = '0;
    e.hi = '0;
    arith = 1'b0;
    full = 0;
    sres = 0;
    case (op)
      4'h0: begin full = ua + ub; sres = sa + sbv; arith = 1'b1; end
      4'h1, 4'hB: begin full = ua + (65535 - ub) + 1; sres = sa - sbv; arith = 1'b1; end
      4'h8: begin full = ua + ub + longint'(prev.c); sres = sa + sbv + longint'(prev.c); arith = 1'b1; end
      4'h9: begin full = ua + (65535 - ub) + longint'(prev.c); sres = sa - sbv - 1 + longint'(prev.c); arith = 1'b1; end
      4'h2: begin e.res = a & b; e.c = 0; e.v = 0; end
      4'h3: begin e.res = a | b; e.c = 0; e.v = 0; end
      4'h4: begin e.res = a ^ b; e.c = 0; e.v = 0; end
      4'h5: begin e.res = ~a;    e.c = 0; e.v = 0; end
      4'h6: begin
        e.res = 16'(ua << s);
        e.c = (s == 0) ? 1'b0 : (((ua >> (16 - s)) & 1) != 0);
        e.v = 0;
      end
      4'h7: begin
        e.res = 16'(ua >> s);
        e.c = (s == 0) ? 1'b0 : (((ua >> (s - 1)) & 1) != 0);
        e.v = 0;
      end
      4'hA: begin
        e.res = 16'(sa >>> s);
        e.c = (s == 0) ? 1'b0 : (((ua >> (s - 1)) & 1) != 0);
        e.v = 0;
      end
      4'hC: begin
        p = ua * ub;
        e.res = 16'(p);
        e.hi = 16'(p >> 16);
        e.z = (p == 0);
        e.n = ((p >> 31) & 1) != 0;
        e.c = (e.hi != 0);
        e.v = (e.hi != 0);
        return e;
      end
      4'hD: begin
        if (ub == 0) begin
          e.res = 16'hFFFF;
          e.hi = a;
          e.c = 1'b1;
        end else begin
          e.res = 16'(ua / ub);
          e.hi = 16'(ua % ub);
          e.c = 1'b0;
        end
        e.v = 1'b0;
        e.z = (e.res == 0);
        e.n = e.res[15];
        return e;
      end
      default: return e;
    endcase
    if (arith) begin
      e.res = (op == 4'hB) ? a : 16'(full);
      e.c = (full > 65535);
      e.v = (sres > 32767) || (sres < -32768);
      zsrc = 16'(full);
    end else begin
      zsrc = e.res;
    end
    e.z = (zsrc == 0);
    e.n = zsrc[15];
    return e;
  endfunction

  // Issue one op when ready; expectation is queued at the accept edge
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      check("issue_ready_timeout", 64'(bus.in_ready), 64'(1));
      return;
    end
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    m_st = model(op, a, b, m_st);
    q_sb.push_back(m_st);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // MUL with in_valid held through BUSY; checks ready-low window and latency
  task automatic mul_hold(input logic [15:0] a, input logic [15:0] b);
    int busy_ready_hi = 0;
    bus.in_valid = 1'b1;
    bus.op = 4'hC;
    bus.a = a;
    bus.b = b;
    m_st = model(4'hC, a, b, m_st);
    q_sb.push_back(m_st);
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      if (bus.in_ready) busy_ready_hi++;
      bus.op = 4'h0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("mul_busy_ready_high_cycles", 64'(busy_ready_hi), 64'(0));
    check("mul_ready_after_done", 64'(bus.in_ready), 64'(1));
    check("mul_latency_out_valid", 64'(bus.out_valid), 64'(1));
  endtask

  // Monitor: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      mon_got = {bus.result, bus.result_hi, bus.zero, bus.negative, bus.carry, bus.overflow};
      if (q_sb.size() == 0) begin
        check("unexpected_out_valid", 64'(mon_got), 64'(0));
        if (mon_got == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid 1 expected 0");
        end
      end else begin
        mon_exp = q_sb.pop_front();
        check("result_flags", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  initial begin
    logic [3:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    int          guard;
    n_checks = 0;
    n_fail = 0;
    m_st = '0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bus.out_valid, bus.result, bus.result_hi, bus.zero,
                                bus.negative, bus.carry, bus.overflow}), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'(bus.in_ready), 64'(1));

    issue(4'h0, 16'h7FFF, 16'h0001);
    issue(4'h1, 16'h000A, 16'h0014);
    issue(4'h0, 16'hFFFF, 16'h0001);
    issue(4'h8, 16'h0000, 16'h0000);
    issue(4'h9, 16'h0005, 16'h0005);
    issue(4'h6, 16'h8001, 16'h0001);
    issue(4'hA, 16'h8000, 16'h0004);
    issue(4'h7, 16'h0010, 16'h0005);
    issue(4'h6, 16'h1234, 16'h0000);
    mul_hold(16'h1234, 16'h0100);
    issue(4'h2, 16'hF0F0, 16'h3C3C);
    issue(4'hD, 16'd100, 16'd7);
    issue(4'hD, 16'h1234, 16'h0000);
    issue(4'hE, 16'hAAAA, 16'h5555);
    issue(4'hF, 16'h0000, 16'h0000);

    // Reset during MUL iteration 5 aborts the op entirely
    bus.in_valid = 1'b1;
    bus.op = 4'hC;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs_zero", 64'({bus.out_valid, bus.result, bus.result_hi, bus.zero,
                                     bus.negative, bus.carry, bus.overflow}), 64'(0));
    check("abort_in_ready_low", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    m_st = '0;
    #1;
    check("abort_ready_after_rst", 64'(bus.in_ready), 64'(1));
    issue(4'hB, 16'h0003, 16'h0003);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      r_op = 4'($urandom_range(0, 15));
      r_a = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      r_b = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      issue(r_op, r_a, r_b);
    end

    guard = 0;
    while (q_sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("scoreboard_drained", 64'(q_sb.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
